// File: rtl/acc_cpu_param_if.sv
// Instruction-memory bus between the accumulator core and its program ROM.
// The core drives the fetch address and the ROM returns the word combinationally.
interface acc_cpu_param_if #(
  parameter int AW = 4
);
  logic [AW-1:0] IADDR;
  logic [AW+3:0] IDATA;

  modport master (output IADDR, input IDATA);
  modport slave  (input IADDR, output IDATA);
endinterface

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU: FETCH/DECODE/EXEC sequencing, internal data RAM,
// Z/C flags with conditional jumps, and a single-step pause state.
module acc_cpu_param #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  acc_cpu_param_if.master        imem,
  input  logic                   STEP_MODE,
  input  logic                   STEP,
  output logic [AW-1:0]          Q_PC,
  output logic [AW+3:0]          IR,
  output logic [DW-1:0]          Dout_ACC,
  output logic                   Z,
  output logic                   C,
  output logic [2:0]             PHASE,
  output logic                   WAITING,
  output logic                   HALTED
);

  if (AW > DW || DW < 4 || DW > 32) begin : g_param_check
    $error("acc_cpu_param: need 4 <= DW <= 32 and AW <= DW");
  end

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_HALT
  } state_t;

  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state, state_nxt;
  logic [AW-1:0]   pc;
  logic [AW+3:0]   ir;
  logic [DW-1:0]   acc, acc_nxt;
  logic            z, z_nxt;
  logic            c, c_nxt;
  logic            step_q;
  logic [DW-1:0]   mdr;
  logic [DW-1:0]   dmem [2**AW];

  logic [3:0]      op;
  logic [AW-1:0]   ir_addr;
  logic            step_edge;
  logic            take_jump;
  logic            dmem_we;
  logic            wr_acc;
  logic [DW:0]     sum_ext;
  logic [DW:0]     diff_ext;

  assign op        = ir[AW+3:AW];
  assign ir_addr   = ir[AW-1:0];
  assign step_edge = STEP & ~step_q;
  assign sum_ext   = {1'b0, acc} + {1'b0, mdr};
  assign diff_ext  = {1'b0, acc} - {1'b0, mdr};

  assign imem.IADDR = pc;
  assign Q_PC       = pc;
  assign IR         = ir;
  assign Dout_ACC   = acc;
  assign Z          = z;
  assign C          = c;
  assign WAITING    = (state == S_WAIT);
  assign HALTED     = (state == S_HALT);

  always_comb begin
    PHASE = 3'b000;
    case (state)
      S_FETCH:  PHASE = 3'b001;
      S_DECODE: PHASE = 3'b010;
      S_EXEC:   PHASE = 3'b100;
      default:  PHASE = 3'b000;
    endcase
  end

  // STEP_MODE is only consulted at the end of EXEC, so the first instruction always runs
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (op == OP_HALT)   state_nxt = S_HALT;
        else if (STEP_MODE)  state_nxt = S_WAIT;
        else                 state_nxt = S_FETCH;
      end
      S_WAIT:   if (step_edge || !STEP_MODE) state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    acc_nxt   = acc;
    z_nxt     = z;
    c_nxt     = c;
    take_jump = 1'b0;
    dmem_we   = 1'b0;
    wr_acc    = 1'b0;
    if (state == S_EXEC) begin
      case (op)
        OP_LD:  begin acc_nxt = mdr; wr_acc = 1'b1; end
        OP_ST:  dmem_we = 1'b1;
        OP_ADD: begin {c_nxt, acc_nxt} = sum_ext;  wr_acc = 1'b1; end
        OP_SUB: begin {c_nxt, acc_nxt} = diff_ext; wr_acc = 1'b1; end
        OP_AND: begin acc_nxt = acc & mdr; c_nxt = 1'b0; wr_acc = 1'b1; end
        OP_OR:  begin acc_nxt = acc | mdr; c_nxt = 1'b0; wr_acc = 1'b1; end
        OP_XOR: begin acc_nxt = acc ^ mdr; c_nxt = 1'b0; wr_acc = 1'b1; end
        OP_SHL: begin c_nxt = acc[DW-1]; acc_nxt = {acc[DW-2:0], 1'b0}; wr_acc = 1'b1; end
        OP_SHR: begin c_nxt = acc[0];    acc_nxt = {1'b0, acc[DW-1:1]}; wr_acc = 1'b1; end
        OP_LDI: begin acc_nxt = DW'(ir_addr); wr_acc = 1'b1; end
        OP_JMP: take_jump = 1'b1;
        OP_JZ:  take_jump = z;
        OP_JC:  take_jump = c;
        default: ;
      endcase
      if (wr_acc) z_nxt = (acc_nxt == '0);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= '0;
      acc    <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      step_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      step_q <= STEP;
      if (state == S_FETCH) begin
        ir <= imem.IDATA;
        pc <= pc + AW'(1);
      end
      if (state == S_EXEC) begin
        acc <= acc_nxt;
        z   <= z_nxt;
        c   <= c_nxt;
        if (take_jump) pc <= ir_addr;
      end
    end
  end

  // Store lands at EXEC end, ahead of the next DECODE read, so ST->LD needs no bypass
  always_ff @(posedge CLK) begin
    if (state == S_DECODE) mdr <= dmem[ir_addr];
    if (dmem_we)           dmem[ir_addr] <= acc;
  end

endmodule
